// File: rtl/wordcopy_dma_if.sv
// Bus bundle for wordcopy_dma: CPU register slave plus SDRAM master port.
// The master modport is the engine's view; slave is the surrounding system (CPU + memory).
interface wordcopy_dma_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              slave_waitrequest;
  logic [3:0]        slave_address;
  logic              slave_read;
  logic [31:0]       slave_readdata;
  logic              slave_write;
  logic [31:0]       slave_writedata;
  logic              master_waitrequest;
  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic [DATA_W-1:0] master_readdata;
  logic              master_readdatavalid;
  logic              master_write;
  logic [DATA_W-1:0] master_writedata;

  modport master (
    output slave_waitrequest, slave_readdata,
    output master_address, master_read, master_write, master_writedata,
    input  slave_address, slave_read, slave_write, slave_writedata,
    input  master_waitrequest, master_readdata, master_readdatavalid
  );

  modport slave (
    input  slave_waitrequest, slave_readdata,
    input  master_address, master_read, master_write, master_writedata,
    output slave_address, slave_read, slave_write, slave_writedata,
    output master_waitrequest, master_readdata, master_readdatavalid
  );
endinterface

// File: rtl/wordcopy_dma.sv
// wordcopy_dma: CPU-programmed copy engine with pipelined reads, read-data FIFO and back-to-back writes.
// Optional fill mode (register 5 pattern, CTRL writedata[1]) is built when WORDCOPY_FILL_EN is defined.
module wordcopy_dma #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input logic            clk,
  input logic            rst_n,
  wordcopy_dma_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic              done_q;
  logic [31:0]       dst_q, src_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  rd_issued, wr_done;
  logic [CW-1:0]     outstanding, fifo_cnt;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

`ifdef WORDCOPY_FILL_EN
  logic [31:0]       fill_q;
  logic              fill_mode;
`else
  logic              fill_mode;
  assign fill_mode = 1'b0;
`endif

  logic              busy, start, push, pop, rd_acc, wr_acc, cmd_free, can_wr, can_rd;
  logic [CNT_W-1:0]  rd_issued_nx, wr_done_nx;
  logic [CW-1:0]     out_nx, fifo_cnt_nx, cnt_after_pop;
  logic [PTR_W-1:0]  rd_ptr_nx, wr_ptr_nx;
  logic [ADDR_W-1:0] rd_addr_nx, wr_addr_nx;
  logic [DATA_W-1:0] wr_head, wr_data;
  logic [31:0]       rdata;
  logic              unused_slave_read;

  assign unused_slave_read = bus.slave_read;

  assign busy   = (state == RUN);
  assign start  = (state == IDLE) && bus.slave_write && (bus.slave_address == 4'd0);
  assign rd_acc = bus.master_read  && !bus.master_waitrequest;
  assign wr_acc = bus.master_write && !bus.master_waitrequest;
  assign push   = busy && bus.master_readdatavalid;
  assign pop    = wr_acc && !fill_mode;

  // Post-edge view of every counter, so a new command can follow an accept without a bubble
  assign rd_issued_nx = rd_issued + CNT_W'(rd_acc);
  assign wr_done_nx   = wr_done + CNT_W'(wr_acc);
  assign out_nx       = outstanding + CW'(rd_acc) - CW'(push);
  assign cnt_after_pop = fifo_cnt - CW'(pop);
  assign fifo_cnt_nx  = cnt_after_pop + CW'(push);
  assign rd_ptr_nx    = rd_ptr + PTR_W'(pop);
  assign wr_ptr_nx    = wr_ptr + PTR_W'(push);
  assign rd_addr_nx   = rd_acc ? rd_addr + STRIDE : rd_addr;
  assign wr_addr_nx   = wr_acc ? wr_addr + STRIDE : wr_addr;

  assign cmd_free = !(bus.master_read || bus.master_write) || rd_acc || wr_acc;
  assign can_wr   = fill_mode ? (wr_done_nx != num_q) : (fifo_cnt_nx != '0);
  assign can_rd   = !fill_mode && (rd_issued_nx < num_q) &&
                    (({1'b0, out_nx} + {1'b0, fifo_cnt_nx}) < (CW+1)'(FIFO_DEPTH));

  // An empty FIFO being pushed this edge has its head on the bus, not yet in the array
  assign wr_head = (cnt_after_pop == '0) ? bus.master_readdata : fifo_mem[rd_ptr_nx];
`ifdef WORDCOPY_FILL_EN
  assign wr_data = fill_mode ? DATA_W'(fill_q) : wr_head;
`else
  assign wr_data = wr_head;
`endif

  assign bus.slave_waitrequest = bus.slave_write && (bus.slave_address == 4'd0) && (state != DONE);

  always_comb begin
    rdata = '0;
    case (bus.slave_address)
`ifdef WORDCOPY_FILL_EN
      4'd0: rdata = {29'b0, fill_mode, done_q, busy};
      4'd5: rdata = fill_q;
`else
      4'd0: rdata = {30'b0, done_q, busy};
`endif
      4'd1: rdata = dst_q;
      4'd2: rdata = src_q;
      4'd3: rdata = 32'(num_q);
      4'd4: rdata = 32'(wr_done);
      default: rdata = '0;
    endcase
  end
  assign bus.slave_readdata = rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q  <= '0;
      src_q  <= '0;
      num_q  <= '0;
`ifdef WORDCOPY_FILL_EN
      fill_q <= '0;
`endif
    end else if (bus.slave_write && !busy) begin
      case (bus.slave_address)
        4'd1: dst_q <= bus.slave_writedata;
        4'd2: src_q <= bus.slave_writedata;
        4'd3: num_q <= CNT_W'(bus.slave_writedata);
`ifdef WORDCOPY_FILL_EN
        4'd5: fill_q <= bus.slave_writedata;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.master_readdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      done_q               <= 1'b0;
      rd_issued            <= '0;
      wr_done              <= '0;
      outstanding          <= '0;
      fifo_cnt             <= '0;
      rd_ptr               <= '0;
      wr_ptr               <= '0;
      rd_addr              <= '0;
      wr_addr              <= '0;
      bus.master_read      <= 1'b0;
      bus.master_write     <= 1'b0;
      bus.master_address   <= '0;
      bus.master_writedata <= '0;
`ifdef WORDCOPY_FILL_EN
      fill_mode            <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            done_q      <= 1'b0;
            rd_issued   <= '0;
            wr_done     <= '0;
            outstanding <= '0;
            fifo_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            rd_addr     <= ADDR_W'(src_q);
            wr_addr     <= ADDR_W'(dst_q);
`ifdef WORDCOPY_FILL_EN
            fill_mode   <= bus.slave_writedata[1];
`endif
          end
        end
        RUN: begin
          rd_issued   <= rd_issued_nx;
          wr_done     <= wr_done_nx;
          outstanding <= out_nx;
          fifo_cnt    <= fifo_cnt_nx;
          rd_ptr      <= rd_ptr_nx;
          wr_ptr      <= wr_ptr_nx;
          rd_addr     <= rd_addr_nx;
          wr_addr     <= wr_addr_nx;
          if (wr_done == num_q) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else if (cmd_free) begin
            // Writes win so the FIFO drains; reads only while credit remains
            bus.master_read  <= 1'b0;
            bus.master_write <= 1'b0;
            if (can_wr) begin
              bus.master_write     <= 1'b1;
              bus.master_address   <= wr_addr_nx;
              bus.master_writedata <= wr_data;
            end else if (can_rd) begin
              bus.master_read    <= 1'b1;
              bus.master_address <= rd_addr_nx;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
